hex_display_arbiter: RTL and testbench

- Shares the six-digit seven-segment display (24-bit hex value plus 6 decimal points) among N_REQ requesters, e.g. CPU debug port, switch monitor and bus tracer.
- Round-robin arbitration with a minimum dwell time per grant, so each page stays readable.
- Sits between the requesters and the per-digit static hex decoders in the board top level.
- Drives number_to_display, the dot mask and a blank flag.

---
 rtl/hex_display_arbiter_if.sv | 39 +++
 rtl/hex_display_arbiter.sv | 134 +++++++++++++
 tb/tb_hex_display_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/hex_display_arbiter_if.sv
// Bundle of signals between the display requesters and the hex display arbiter.
//   master : requester side. It drives req/value/dots/hold and observes the grant and the display page.
//   slave  : arbiter side. It drives the grant and the registered display outputs.
// Signals:
//   req[N_REQ]                   level request per requester
//   value[N_REQ*DIGITS*4]        flattened pages; requester i uses [i*DIGITS*4 +: DIGITS*4]
//   dots[N_REQ*DIGITS]           flattened dot masks; requester i uses [i*DIGITS +: DIGITS]
//   hold                         freezes the dwell counter
//   grant[N_REQ]                 one-hot owner; zero when idle
//   grant_id[$clog2(N_REQ)]      binary owner index; the last owner is kept while idle
//   number_to_display[DIGITS*4]  registered page of the owner
//   dots_out[DIGITS]             registered dot mask of the owner
//   blank                        high when there is no owner
interface hex_display_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DIGITS = 6
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]          req;
    logic [N_REQ*DIGITS*4-1:0] value;
    logic [N_REQ*DIGITS-1:0]   dots;
    logic                      hold;
    logic [N_REQ-1:0]          grant;
    logic [ID_W-1:0]           grant_id;
    logic [DIGITS*4-1:0]       number_to_display;
    logic [DIGITS-1:0]         dots_out;
    logic                      blank;

    modport master (
        output req, value, dots, hold,
        input  grant, grant_id, number_to_display, dots_out, blank
    );

    modport slave (
        input  req, value, dots, hold,
        output grant, grant_id, number_to_display, dots_out, blank
    );
endinterface

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter that shares the six-digit hex display among N_REQ requesters.
// Each grant is held for a minimum dwell time so that every page stays readable.
// All outputs are registered.
// Ports:
//   clk      system clock
//   reset_n  asynchronous reset, active low
//   arb_if   requests, pages and dot masks in; grant and display page out (slave modport)
//
// state | meaning
// IDLE  | no owner; display blanked and cleared; waiting for any request
// SHOW  | one owner; its page is copied to the display every cycle; the dwell counter runs
module hex_display_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DIGITS       = 6,
    parameter int DWELL_CYCLES = 25000000,
    parameter int CNT_W        = $clog2(DWELL_CYCLES)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    hex_display_arbiter_if.slave arb_if
);
    localparam int ID_W = $clog2(N_REQ);
    localparam int VW   = DIGITS * 4;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [ID_W-1:0]  ID_LAST    = ID_W'(N_REQ - 1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [VW-1:0]     num_q, num_d;
    logic [DIGITS-1:0] dots_q, dots_d;
    logic              blank_q, blank_d;

    logic              rr_found;
    logic [ID_W-1:0]   rr_pick;
    int                rr_idx;

    // Scan from grant_id+1 upward with wrap-around. The current owner is visited last,
    // so that at dwell expiry it keeps the grant only when no other requester is waiting.
    // The loop runs downward so that the nearest requester is the last one written.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = grant_id_q;
        rr_idx   = 0;
        for (int i = N_REQ; i >= 1; i--) begin
            rr_idx = (int'(grant_id_q) + i) % N_REQ;
            if (arb_if.req[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = ID_W'(rr_idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        cnt_d      = cnt_q;
        num_d      = num_q;
        dots_d     = dots_q;
        grant_d    = grant_q;
        blank_d    = blank_q;

        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    state_d    = SHOW;
                    grant_id_d = rr_pick;
                    cnt_d      = CNT_RELOAD;
                end
            end
            SHOW: begin
                num_d  = arb_if.value[grant_id_q*VW +: VW];
                dots_d = arb_if.dots[grant_id_q*DIGITS +: DIGITS];
                if (!arb_if.req[grant_id_q]) begin
                    // Early release: dwell time and hold do not apply.
                    if (rr_found) begin
                        grant_id_d = rr_pick;
                        cnt_d      = CNT_RELOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!arb_if.hold) begin
                    if (cnt_q == '0) begin
                        grant_id_d = rr_pick;
                        cnt_d      = CNT_RELOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            grant_d = '0;
            cnt_d   = '0;
            num_d   = '0;
            dots_d  = '0;
            blank_d = 1'b1;
        end else begin
            grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id_d;
            blank_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= ID_LAST;
            cnt_q      <= '0;
            num_q      <= '0;
            dots_q     <= '0;
            blank_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            cnt_q      <= cnt_d;
            num_q      <= num_d;
            dots_q     <= dots_d;
            blank_q    <= blank_d;
        end
    end

    assign arb_if.grant             = grant_q;
    assign arb_if.grant_id          = grant_id_q;
    assign arb_if.number_to_display = num_q;
    assign arb_if.dots_out          = dots_q;
    assign arb_if.blank             = blank_q;
endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench for hex_display_arbiter with N_REQ=4, DIGITS=6, DWELL_CYCLES=4.
// Expected per-cycle display states are queued alongside each stimulus step and popped
// one per clock, 1 time unit after the rising edge.
module tb_hex_display_arbiter;
    localparam int N_REQ  = 4;
    localparam int DIGITS = 6;
    localparam int DWELL  = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    hex_display_arbiter_if #(.N_REQ(N_REQ), .DIGITS(DIGITS)) arb_if ();

    hex_display_arbiter #(
        .N_REQ       (N_REQ),
        .DIGITS      (DIGITS),
        .DWELL_CYCLES(DWELL)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .arb_if (arb_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [3:0]  grant;
        logic [1:0]  id;
        logic [23:0] num;
        logic [5:0]  dots;
        logic        blank;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [23:0] pg_val [4] = '{24'h123456, 24'hABCDEF, 24'h0F0F0F, 24'h987654};
    logic [5:0]  pg_dot [4] = '{6'b000001, 6'b000010, 6'b000100, 6'b101000};

    // Queue n cycles of expectations. owner<0 means idle. The first cycle shows first_pg and
    // the remaining cycles show rest_pg (page index, or -1 for a cleared display).
    task automatic push_run(input string tag, input int owner, input int id,
                            input int first_pg, input int rest_pg, input int n);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            int   pg;
            pg      = (k == 0) ? first_pg : rest_pg;
            e.tag   = tag;
            e.grant = (owner < 0) ? 4'b0000 : (4'b0001 << owner);
            e.id    = 2'(id);
            e.num   = (pg < 0) ? 24'h0 : pg_val[pg];
            e.dots  = (pg < 0) ? 6'h0 : pg_dot[pg];
            e.blank = (owner < 0);
            sb.push_back(e);
        end
    endtask

    task automatic check_one();
        exp_t e;
        n_checks++;
        assert (sb.size() != 0) else begin
            n_errors++;
            $error("FAIL sb_underflow: got size %0d want >0", sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_checks++;
            assert (arb_if.grant === e.grant) else begin
                n_errors++;
                $error("FAIL %s grant: got %b want %b", e.tag, arb_if.grant, e.grant);
            end
            n_checks++;
            assert (arb_if.grant_id === e.id) else begin
                n_errors++;
                $error("FAIL %s grant_id: got %0d want %0d", e.tag, arb_if.grant_id, e.id);
            end
            n_checks++;
            assert (arb_if.number_to_display === e.num) else begin
                n_errors++;
                $error("FAIL %s number: got %h want %h", e.tag, arb_if.number_to_display, e.num);
            end
            n_checks++;
            assert (arb_if.dots_out === e.dots) else begin
                n_errors++;
                $error("FAIL %s dots: got %b want %b", e.tag, arb_if.dots_out, e.dots);
            end
            n_checks++;
            assert (arb_if.blank === e.blank) else begin
                n_errors++;
                $error("FAIL %s blank: got %b want %b", e.tag, arb_if.blank, e.blank);
            end
        end
    endtask

    task automatic run_checks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            check_one();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arb_if.req  = '0;
        arb_if.hold = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            arb_if.value[i*24 +: 24] = pg_val[i];
            arb_if.dots[i*6 +: 6]    = pg_dot[i];
        end

        // Reset values, then idle with no requests.
        #12;
        push_run("reset", -1, 3, -1, -1, 1);
        check_one();
        @(negedge clk);
        reset_n = 1'b1;
        push_run("idle", -1, 3, -1, -1, 10);
        run_checks(10);

        // Single requester: grant after 1 cycle, page after 2, kept across dwell expiries.
        arb_if.req = 4'b0001;
        push_run("single", 0, 0, -1, 0, 10);
        run_checks(10);

        // Three requesters: rotation 0 -> 1 -> 3 -> 0 -> 1, 4 cycles each, display lags by 1.
        arb_if.req = 4'b1011;
        push_run("rr_own0", 0, 0, 0, 0, 2);
        push_run("rr_own1", 1, 1, 0, 1, 4);
        push_run("rr_own3", 3, 3, 1, 3, 4);
        push_run("rr_own0b", 0, 0, 3, 0, 4);
        push_run("rr_own1b", 1, 1, 0, 1, 2);
        run_checks(16);

        // Owner 1 drops at dwell cycle 2: owner 3 takes over with a full 4-cycle dwell.
        arb_if.req = 4'b1001;
        push_run("early_rel", 3, 3, 1, 3, 4);
        push_run("after_rel", 0, 0, 3, 0, 2);
        run_checks(6);

        // All requests drop: idle next cycle, last owner retained.
        arb_if.req = 4'b0000;
        push_run("to_idle", -1, 0, -1, -1, 2);
        run_checks(2);

        // Hold during owner 0's dwell keeps the grant; release lets the dwell finish.
        arb_if.req = 4'b0001;
        push_run("hold_grab", 0, 0, -1, -1, 1);
        run_checks(1);
        arb_if.req  = 4'b0011;
        arb_if.hold = 1'b1;
        push_run("hold_on", 0, 0, 0, 0, 20);
        run_checks(20);
        arb_if.hold = 1'b0;
        push_run("hold_off", 0, 0, 0, 0, 3);
        push_run("hold_switch", 1, 1, 0, 1, 2);
        run_checks(5);

        // Asynchronous reset mid-SHOW, then requester 0 is served first.
        #3;
        reset_n = 1'b0;
        #2;
        push_run("async_rst", -1, 3, -1, -1, 1);
        check_one();
        @(negedge clk);
        reset_n = 1'b1;
        push_run("post_rst", 0, 0, -1, 0, 2);
        run_checks(2);

        n_checks++;
        assert (sb.size() == 0) else begin
            n_errors++;
            $error("FAIL sb_leftover: got %0d want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
